bcd_serial_addsub: RTL and testbench

//  Parametrised multi-digit BCD adder/subtractor. Processes one decimal digit per clock, LSD first,

---
 rtl/bcd_serial_addsub_pkg.sv | 22 ++
 rtl/bcd_serial_addsub_if.sv | 25 ++
 rtl/bcd_serial_addsub_digit_add.sv | 19 +
 rtl/bcd_serial_addsub.sv | 105 ++++++++++
 tb/tb_bcd_serial_addsub.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_serial_addsub_pkg.sv
// Shared BCD definitions: digit width, decimal limits, FSM state encoding
// and small per-digit helpers used by the serial BCD add/sub block.
package bcd_serial_addsub_pkg;
  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [3:0]  BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 9's complement, wraps mod 16 for illegal digits (kept deterministic)
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

  function automatic logic bad_digit(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Handshake/data bundle for bcd_serial_addsub.
//  master: producer/consumer side (drives operands, out_ready)
//  slave : the adder (drives in_ready, result, flags)
interface bcd_serial_addsub_if #(parameter int DIGITS = 4);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   op_a;
  logic [4*DIGITS-1:0]   op_b;
  logic                  sub;
  logic                  c_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  c_out;
  logic                  err;

  modport master (
    output in_valid, op_a, op_b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, err
  );
  modport slave (
    input  in_valid, op_a, op_b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, err
  );
endinterface

// File: rtl/bcd_serial_addsub_digit_add.sv
// bcd_digit_add: one corrected BCD digit adder (combinational).
//  i_a, i_b : digits, i_ci : carry in
//  o_s      : corrected digit, o_co : decimal carry out
module bcd_digit_add
  import bcd_serial_addsub_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);
  logic [4:0] w_t;

  assign w_t  = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_ci};
  assign o_co = w_t > {1'b0, BCD_MAX};
  // (t+6)[3:0] == t[3:0]+6 mod 16
  assign o_s  = o_co ? (w_t[3:0] + BCD_ADJ) : w_t[3:0];
endmodule

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: multi-digit BCD adder/subtractor, one digit per clock,
// LSD first, through a single bcd_digit_add.
//  clk, rst_n : clock, async active-low reset
//  bus        : slave side of bcd_serial_addsub_if (valid/ready in, valid/ready out,
//               op_a/op_b/sub/c_in operands, sum/c_out/err result)
// Subtraction is done as A + 9's-comp(B) + !borrow_in, so c_out=1 means no borrow.
module bcd_serial_addsub
  import bcd_serial_addsub_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_serial_addsub_if.slave bus
);
  localparam int W  = BCD_W * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_a, r_b, r_sum;
  logic           r_carry, r_c_out, r_err, r_out_valid;

  logic [W-1:0]   w_bop, w_sum_nxt;
  logic           w_bad;
  logic [3:0]     w_s;
  logic           w_co;

  // operand B as presented to the adder, plus raw-digit legality check
  always_comb begin
    w_bop = '0;
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_bop[BCD_W*i +: BCD_W] = bus.sub ? nines_comp(bus.op_b[BCD_W*i +: BCD_W])
                                        : bus.op_b[BCD_W*i +: BCD_W];
      w_bad = w_bad | bad_digit(bus.op_a[BCD_W*i +: BCD_W])
                    | bad_digit(bus.op_b[BCD_W*i +: BCD_W]);
    end
  end

  // operands are shifted right, so the current digit is always at [3:0]
  bcd_digit_add u_dig (
    .i_a  (r_a[3:0]),
    .i_b  (r_b[3:0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // new digit enters at the MSD end; after DIGITS shifts digit 0 lands at [3:0]
  assign w_sum_nxt = (r_sum >> BCD_W) | (W'(w_s) << (W - BCD_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_c_out     <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.op_a;
            r_b     <= w_bop;
            r_carry <= bus.c_in ^ bus.sub;
            r_err   <= w_bad;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum   <= w_sum_nxt;
          r_a     <= r_a >> BCD_W;
          r_b     <= r_b >> BCD_W;
          r_carry <= w_co;
          if (r_cnt == CW'(DIGITS - 1)) begin
            r_c_out     <= w_co;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_c_out;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench: three instances (DIGITS=4, 1, 8) checked against a
// decimal-integer reference model.
module tb_bcd_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_addsub_if #(.DIGITS(4)) b4();
  bcd_serial_addsub_if #(.DIGITS(1)) b1();
  bcd_serial_addsub_if #(.DIGITS(8)) b8();

  bcd_serial_addsub #(.DIGITS(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  bcd_serial_addsub #(.DIGITS(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  bcd_serial_addsub #(.DIGITS(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (plain decimal arithmetic) ----------------
  function automatic longint pow10(input int d);
    longint r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint bcd2int(input logic [31:0] v, input int d);
    longint r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input longint n, input int d);
    logic [31:0] r = '0;
    longint      m = n;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_bcd(input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic ci, input int d,
                       output logic [31:0] es, output logic ec);
    longint m = pow10(d);
    longint t;
    if (!s) begin
      t  = bcd2int(a, d) + bcd2int(b, d) + longint'(ci);
      ec = (t >= m);
      es = int2bcd(t % m, d);
    end else begin
      t  = bcd2int(a, d) - bcd2int(b, d) - longint'(ci);
      ec = (t >= 0);
      if (t < 0) t = t + m;
      es = int2bcd(t, d);
    end
  endtask

  // ---------------- per-instance access ----------------
  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic ci, input logic v);
    case (w)
      0: begin b4.op_a = a[15:0]; b4.op_b = b[15:0]; b4.sub = s; b4.c_in = ci; b4.in_valid = v; end
      1: begin b1.op_a = a[3:0];  b1.op_b = b[3:0];  b1.sub = s; b1.c_in = ci; b1.in_valid = v; end
      default: begin b8.op_a = a; b8.op_b = b; b8.sub = s; b8.c_in = ci; b8.in_valid = v; end
    endcase
  endtask

  task automatic set_ordy(input int w, input logic v);
    case (w)
      0: b4.out_ready = v;
      1: b1.out_ready = v;
      default: b8.out_ready = v;
    endcase
  endtask

  task automatic sample(input int w, output logic ov, output logic ir,
                        output logic [31:0] sm, output logic co, output logic er);
    case (w)
      0: begin ov = b4.out_valid; ir = b4.in_ready; sm = 32'(b4.sum); co = b4.c_out; er = b4.err; end
      1: begin ov = b1.out_valid; ir = b1.in_ready; sm = 32'(b1.sum); co = b1.c_out; er = b1.err; end
      default: begin ov = b8.out_valid; ir = b8.in_ready; sm = b8.sum; co = b8.c_out; er = b8.err; end
    endcase
  endtask

  // one full transaction; 'hold' cycles of out_ready=0 with in_valid pulses in DONE
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ci, input int hold,
                        output logic [31:0] sm, output logic co, output logic er,
                        output int lat);
    logic ov, ir, co2, er2;
    logic [31:0] sm2;
    drive(w, a, b, s, ci, 1'b1);
    @(posedge clk); #1;
    drive(w, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    lat = 0;
    ov  = 1'b0;
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      sample(w, ov, ir, sm, co, er);
    end
    if (!ov) chk("timeout_out_valid", 32'(ov), 32'd1);
    for (int k = 0; k < hold; k++) begin
      drive(w, rnd_bcd(8), rnd_bcd(8), 1'($urandom_range(0, 1)), 1'b1, (k % 2) == 0);
      @(posedge clk); #1;
      sample(w, ov, ir, sm2, co2, er2);
      chk("hold_sum", sm2, sm);
      chk("hold_cout", 32'(co2), 32'(co));
      chk("hold_in_ready", 32'(ir), 32'd0);
      chk("hold_out_valid", 32'(ov), 32'd1);
    end
    drive(w, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    set_ordy(w, 1'b1);
    @(posedge clk); #1;
    set_ordy(w, 1'b0);
    sample(w, ov, ir, sm2, co2, er2);
    chk("rel_out_valid", 32'(ov), 32'd0);
    chk("rel_in_ready", 32'(ir), 32'd1);
  endtask

  task automatic check_op(input string tag, input int w, input int d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic ci, input int hold);
    logic [31:0] sm, es;
    logic        co, er, ec;
    int          lat;
    run_op(w, a, b, s, ci, hold, sm, co, er, lat);
    model(a, b, s, ci, d, es, ec);
    chk({tag, "_sum"},  sm, es);
    chk({tag, "_cout"}, 32'(co), 32'(ec));
    chk({tag, "_err"},  32'(er), 32'd0);
    chk({tag, "_lat"},  32'(lat), 32'(d));
  endtask

  initial begin
    logic [31:0] sm;
    logic        co, er, ov, ir;
    int          lat;

    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0); drive(2, 0, 0, 0, 0, 0);
    set_ordy(0, 0); set_ordy(1, 0); set_ordy(2, 0);

    // reset state
    #12;
    sample(0, ov, ir, sm, co, er);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_in_ready", 32'(ir), 32'd1);
    chk("rst_sum", sm, 32'd0);
    chk("rst_cout", 32'(co), 32'd0);
    chk("rst_err", 32'(er), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    check_op("add1234_5678", 0, 4, 32'h1234, 32'h5678, 1'b0, 1'b0, 0);
    check_op("add9999_0001", 0, 4, 32'h9999, 32'h0001, 1'b0, 1'b0, 0);
    check_op("add0999_0000c", 0, 4, 32'h0999, 32'h0000, 1'b0, 1'b1, 0);
    check_op("sub5000_1234", 0, 4, 32'h5000, 32'h1234, 1'b1, 1'b0, 0);
    check_op("sub1234_5000", 0, 4, 32'h1234, 32'h5000, 1'b1, 1'b0, 0);
    check_op("sub0000_0000b", 0, 4, 32'h0000, 32'h0000, 1'b1, 1'b1, 0);
    // explicit spot values independent of the model
    run_op(0, 32'h1234, 32'h5678, 1'b0, 1'b0, 0, sm, co, er, lat);
    chk("lit_6912", sm, 32'h6912);
    run_op(0, 32'h0001, 32'h0002, 1'b1, 1'b0, 0, sm, co, er, lat);
    chk("lit_9999", sm, 32'h9999);
    chk("lit_9999_cout", 32'(co), 32'd0);

    // illegal digit flags err, next legal op clears it
    run_op(0, 32'h12A4, 32'h0000, 1'b0, 1'b0, 0, sm, co, er, lat);
    chk("bad_digit_err", 32'(er), 32'd1);
    run_op(0, 32'h0000, 32'h00F0, 1'b1, 1'b0, 0, sm, co, er, lat);
    chk("bad_digit_b_err", 32'(er), 32'd1);
    check_op("after_bad", 0, 4, 32'h0042, 32'h0017, 1'b0, 1'b0, 0);

    // stalled consumer with ignored in_valid pulses
    check_op("hold6", 0, 4, 32'h4321, 32'h2468, 1'b0, 1'b1, 6);

    // reset during RUN, counter at digit 2, with err already set
    drive(0, 32'h12A4, 32'h9999, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk); #1;
    sample(0, ov, ir, sm, co, er);
    chk("pre_rst_err", 32'(er), 32'd1);
    rst_n = 1'b0;
    #1;
    sample(0, ov, ir, sm, co, er);
    chk("midrst_out_valid", 32'(ov), 32'd0);
    chk("midrst_sum", sm, 32'd0);
    chk("midrst_cout", 32'(co), 32'd0);
    chk("midrst_err", 32'(er), 32'd0);
    chk("midrst_in_ready", 32'(ir), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_op("post_rst", 0, 4, 32'h1234, 32'h5678, 1'b0, 1'b0, 0);

    // DIGITS=1
    check_op("d1_7p8", 1, 1, 32'h7, 32'h8, 1'b0, 1'b0, 0);
    run_op(1, 32'h7, 32'h8, 1'b0, 1'b0, 0, sm, co, er, lat);
    chk("d1_lit_sum", sm, 32'h5);
    chk("d1_lit_cout", 32'(co), 32'd1);
    for (int i = 0; i < 8; i++)
      check_op("d1_rnd", 1, 1, rnd_bcd(1), rnd_bcd(1),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    // randomized, DIGITS=4 and DIGITS=8
    for (int i = 0; i < 25; i++)
      check_op("d4_rnd", 0, 4, rnd_bcd(4), rnd_bcd(4),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 25; i++)
      check_op("d8_rnd", 2, 8, rnd_bcd(8), rnd_bcd(8),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    check_op("d8_max", 2, 8, 32'h99999999, 32'h00000001, 1'b0, 1'b0, 0);
    check_op("d8_borrow", 2, 8, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
